// File: rtl/tb_sched.sv
// Traceback scheduler: rotates 4 survivor banks, drives the two TBU lanes and
// re-orders the time-reversed decoded bits through a ping-pong buffer.
module tb_sched #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          dec_valid,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [AW-1:0] mem_raddr,
    output logic [1:0]    trn_bank,
    output logic [1:0]    dec_bank,
    output logic          tbu0_en,
    output logic          tbu1_en,
    output logic          tbu0_sel,
    output logic          tbu1_sel,
    input  logic          tbu0_d_o,
    input  logic          tbu0_wr_en,
    input  logic          tbu1_d_o,
    input  logic          tbu1_wr_en,
    output logic          out_valid,
    output logic          out_bit,
    output logic          err
);
    localparam int unsigned L = 2 ** AW;
    localparam logic [AW-1:0] LAST = AW'(L - 1);

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

    state_e        state_q, state_d;
    logic [1:0]    wr_bank_q, wr_bank_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          parity_q, parity_d;
    logic          sel1_q, sel1_d;
    logic [1:0]    frm_cnt_q, frm_cnt_d;
    logic          err_q, err_d;
    logic [AW-1:0] cap_cnt_q, cap_cnt_d;
    logic          wbuf_q, wbuf_d;
    logic          drain_q, drain_d;
    logic [AW-1:0] drain_idx_q, drain_idx_d;
    logic [L-1:0]  rbuf_q [2];

    logic accept, gap, wrap, cap, both, swap, overflow, cap_bit, active;

    always_comb begin
        accept   = en & dec_valid;
        gap      = en & ~dec_valid & (state_q != StIdle);
        wrap     = accept & (waddr_q == LAST);
        cap      = accept & (state_q == StRun) & (tbu0_wr_en | tbu1_wr_en);
        both     = accept & (state_q == StRun) & tbu0_wr_en & tbu1_wr_en;
        cap_bit  = tbu0_wr_en ? tbu0_d_o : tbu1_d_o;
        swap     = cap & (cap_cnt_q == LAST);
        // A drain on its last beat can hand over to the next frame in the same cycle
        overflow = swap & drain_q & (drain_idx_q != LAST);
    end

    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        waddr_d     = waddr_q;
        parity_d    = parity_q;
        sel1_d      = sel1_q;
        frm_cnt_d   = frm_cnt_q;
        err_d       = err_q;
        cap_cnt_d   = cap_cnt_q;
        wbuf_d      = wbuf_q;
        drain_d     = drain_q;
        drain_idx_d = drain_idx_q;

        case (state_q)
            StIdle:  if (accept) state_d = StFill;
            StFill:  if (wrap && frm_cnt_q == 2'd2) state_d = StRun;
            default: ;
        endcase

        if (accept) waddr_d = waddr_q + AW'(1);
        if (wrap) begin
            wr_bank_d = wr_bank_q + 2'd1;
            parity_d  = ~parity_q;
            sel1_d    = parity_q;
            if (frm_cnt_q != 2'd3) frm_cnt_d = frm_cnt_q + 2'd1;
        end

        if (drain_q) begin
            drain_idx_d = drain_idx_q + AW'(1);
            if (drain_idx_q == LAST) drain_d = 1'b0;
        end
        if (cap) cap_cnt_d = cap_cnt_q + AW'(1);
        if (swap && !overflow) begin
            wbuf_d      = ~wbuf_q;
            drain_d     = 1'b1;
            drain_idx_d = '0;
        end

        if (gap || both || overflow) err_d = 1'b1;

        // Flush and stream gaps both restart the whole schedule from bank 0
        if (!en || gap) begin
            state_d     = StIdle;
            wr_bank_d   = 2'd0;
            waddr_d     = '0;
            parity_d    = 1'b0;
            sel1_d      = 1'b0;
            frm_cnt_d   = 2'd0;
            cap_cnt_d   = '0;
            wbuf_d      = 1'b0;
            drain_d     = 1'b0;
            drain_idx_d = '0;
        end
        if (!en) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_bank_q   <= 2'd0;
            waddr_q     <= '0;
            parity_q    <= 1'b0;
            sel1_q      <= 1'b0;
            frm_cnt_q   <= 2'd0;
            err_q       <= 1'b0;
            cap_cnt_q   <= '0;
            wbuf_q      <= 1'b0;
            drain_q     <= 1'b0;
            drain_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            waddr_q     <= waddr_d;
            parity_q    <= parity_d;
            sel1_q      <= sel1_d;
            frm_cnt_q   <= frm_cnt_d;
            err_q       <= err_d;
            cap_cnt_q   <= cap_cnt_d;
            wbuf_q      <= wbuf_d;
            drain_q     <= drain_d;
            drain_idx_q <= drain_idx_d;
        end
    end

    // Bit storage needs no reset; out_bit is masked while no drain is active
    always_ff @(posedge clk) begin
        if (cap) rbuf_q[wbuf_q][LAST - cap_cnt_q] <= cap_bit;
    end

    always_comb begin
        active    = (state_q != StIdle);
        mem_we    = accept ? (4'b0001 << wr_bank_q) : 4'b0000;
        mem_waddr = waddr_q;
        mem_raddr = LAST - waddr_q;
        trn_bank  = active ? wr_bank_q - 2'd1 : 2'd0;
        dec_bank  = active ? wr_bank_q - 2'd3 : 2'd0;
        tbu0_en   = active & (frm_cnt_q != 2'd0);
        tbu1_en   = active & (frm_cnt_q != 2'd0);
        tbu0_sel  = parity_q;
        tbu1_sel  = sel1_q;
        out_valid = drain_q;
        out_bit   = drain_q & rbuf_q[~wbuf_q][drain_idx_q];
        err       = err_q;
    end
endmodule

// File: tb/tb_tb_sched.sv
// Self-checking bench for tb_sched: frame-level reference model plus
// checkpoint table and directed corner-case sequences.
`timescale 1ns/1ps
module tb_tb_sched;
    localparam int AW = 4;
    localparam int L  = 16;

    logic          clk = 1'b0;
    logic          rst, en, dec_valid;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [1:0]    trn_bank, dec_bank;
    logic          tbu0_en, tbu1_en, tbu0_sel, tbu1_sel;
    logic          tbu0_d_o, tbu0_wr_en, tbu1_d_o, tbu1_wr_en;
    logic          out_valid, out_bit, err;

    always #5 clk = ~clk;

    tb_sched #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .dec_valid(dec_valid),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .trn_bank(trn_bank), .dec_bank(dec_bank),
        .tbu0_en(tbu0_en), .tbu1_en(tbu1_en), .tbu0_sel(tbu0_sel), .tbu1_sel(tbu1_sel),
        .tbu0_d_o(tbu0_d_o), .tbu0_wr_en(tbu0_wr_en),
        .tbu1_d_o(tbu1_d_o), .tbu1_wr_en(tbu1_wr_en),
        .out_valid(out_valid), .out_bit(out_bit), .err(err)
    );

    typedef struct {
        int         t;
        logic [3:0] we;
        logic [3:0] raddr;
        logic       ena;
        logic       sel0;
        logic       sel1;
        logic [1:0] trn;
        logic [1:0] dec;
    } vec_t;

    vec_t vecs[7];

    int n_chk, n_fail;
    int t, ncap, drain_start;
    logic [L-1:0] drain_bits, cap_bits, pat;
    logic err_exp, logging;
    logic [3:0] lg_we [128];
    logic [3:0] lg_raddr [128];
    logic       lg_en0 [128], lg_en1 [128], lg_sel0 [128], lg_sel1 [128];
    logic [1:0] lg_trn [128], lg_dec [128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; dec_valid = 1'b0;
        tbu0_wr_en = 1'b0; tbu1_wr_en = 1'b0; tbu0_d_o = 1'b0; tbu1_d_o = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        t = 0; ncap = 0; drain_start = -1000; err_exp = 1'b0;
    endtask

    // mode: 0 no captures, 1 random lane, 2 lane 0 pattern, 3 both lanes pattern
    task automatic run_stream(input int ncyc, input int mode);
        for (int i = 0; i < ncyc; i++) begin
            int f, a, bank, r;
            logic c0, c1, b0, b1, dv;
            logic [3:0] ew;
            f = t / L; a = t % L; bank = f % 4;
            c0 = 1'b0; c1 = 1'b0; b0 = 1'b0; b1 = 1'b0;
            if (f >= 3) begin
                case (mode)
                    1: begin
                        r  = $urandom_range(0, 3);
                        c0 = (r == 1); c1 = (r == 2);
                        b0 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
                    end
                    2: begin c0 = 1'b1; b0 = pat[L-1-ncap]; end
                    3: begin c0 = 1'b1; c1 = 1'b1; b0 = pat[L-1-ncap]; b1 = ~b0; end
                    default: ;
                endcase
            end
            en = 1'b1; dec_valid = 1'b1;
            tbu0_wr_en = c0; tbu1_wr_en = c1; tbu0_d_o = b0; tbu1_d_o = b1;
            #1;
            ew = 4'(1 << bank);
            chk("mem_we", mem_we, ew);
            chk("mem_waddr", mem_waddr, a);
            chk("mem_raddr", mem_raddr, L - 1 - a);
            chk("tbu0_en", tbu0_en, f >= 1);
            chk("tbu1_en", tbu1_en, f >= 1);
            if (f >= 1) begin
                chk("tbu0_sel", tbu0_sel, f % 2);
                chk("tbu1_sel", tbu1_sel, 1 - f % 2);
                chk("trn_bank", trn_bank, (bank + 3) % 4);
                chk("dec_bank", dec_bank, (bank + 1) % 4);
            end
            dv = (t >= drain_start) && (t < drain_start + L);
            chk("out_valid", out_valid, dv);
            chk("out_bit", out_bit, dv ? drain_bits[t-drain_start] : 1'b0);
            chk("err", err, err_exp);
            if (logging && t < 128) begin
                lg_we[t] = mem_we; lg_raddr[t] = mem_raddr;
                lg_en0[t] = tbu0_en; lg_en1[t] = tbu1_en;
                lg_sel0[t] = tbu0_sel; lg_sel1[t] = tbu1_sel;
                lg_trn[t] = trn_bank; lg_dec[t] = dec_bank;
            end
            if (c0 | c1) begin
                cap_bits[ncap] = c0 ? b0 : b1;
                ncap++;
                if (c0 & c1) err_exp = 1'b1;
                if (ncap == L) begin
                    for (int k = 0; k < L; k++) drain_bits[k] = cap_bits[L-1-k];
                    drain_start = t + 1;
                    ncap = 0;
                end
            end
            @(posedge clk); #1;
            t++;
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; logging = 1'b0; t = 0;
        pat = 16'hB35A;
        vecs[0] = '{16, 4'b0010, 4'd15, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2};
        vecs[1] = '{31, 4'b0010, 4'd0,  1'b1, 1'b1, 1'b0, 2'd0, 2'd2};
        vecs[2] = '{32, 4'b0100, 4'd15, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3};
        vecs[3] = '{47, 4'b0100, 4'd0,  1'b1, 1'b0, 1'b1, 2'd1, 2'd3};
        vecs[4] = '{48, 4'b1000, 4'd15, 1'b1, 1'b1, 1'b0, 2'd2, 2'd0};
        vecs[5] = '{64, 4'b0001, 4'd15, 1'b1, 1'b0, 1'b1, 2'd3, 2'd1};
        vecs[6] = '{80, 4'b0010, 4'd15, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2};

        // Reset state
        rst = 1'b1; en = 1'b0; dec_valid = 1'b0;
        tbu0_wr_en = 1'b0; tbu1_wr_en = 1'b0; tbu0_d_o = 1'b0; tbu1_d_o = 1'b0;
        #12;
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_waddr", mem_waddr, 0);
        chk("rst mem_raddr", mem_raddr, L - 1);
        chk("rst trn_bank", trn_bank, 0);
        chk("rst dec_bank", dec_bank, 0);
        chk("rst tbu_en", {tbu0_en, tbu1_en, tbu0_sel, tbu1_sel}, 0);
        chk("rst out", {out_valid, out_bit, err}, 0);

        // Continuous stream, lane 0 feeds the reversed pattern from frame 3 on
        do_reset();
        logging = 1'b1;
        run_stream(96, 2);
        logging = 1'b0;
        for (int i = 0; i < 7; i++) begin
            int tt;
            tt = vecs[i].t;
            chk("vec mem_we", lg_we[tt], vecs[i].we);
            chk("vec mem_raddr", lg_raddr[tt], vecs[i].raddr);
            chk("vec tbu_en", {lg_en0[tt], lg_en1[tt]}, {vecs[i].ena, vecs[i].ena});
            chk("vec sel", {lg_sel0[tt], lg_sel1[tt]}, {vecs[i].sel0, vecs[i].sel1});
            chk("vec trn_bank", lg_trn[tt], vecs[i].trn);
            chk("vec dec_bank", lg_dec[tt], vecs[i].dec);
        end

        // Random lane activity
        do_reset();
        run_stream(160, 1);

        // Gap at waddr 7 in RUN
        do_reset();
        run_stream(3 * L + 7, 2);
        en = 1'b1; dec_valid = 1'b0; tbu0_wr_en = 1'b0; #1;
        chk("gap mem_we", mem_we, 0);
        @(posedge clk); #1;
        chk("gap err", err, 1);
        chk("gap tbu_en", {tbu0_en, tbu1_en}, 0);
        chk("gap out_valid", out_valid, 0);
        chk("gap trn_bank", trn_bank, 0);
        dec_valid = 1'b1; #1;
        chk("restart mem_we", mem_we, 4'b0001);
        chk("restart waddr", mem_waddr, 0);
        @(posedge clk); #1;
        chk("gap err sticky", err, 1);
        chk("restart out_valid", out_valid, 0);
        en = 1'b0; dec_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush err", err, 0);
        chk("flush tbu_en", {tbu0_en, tbu1_en}, 0);

        // Both lanes valid: lane 0 wins and err is raised
        do_reset();
        run_stream(4 * L + 4, 3);
        chk("both err", err, 1);

        // Reset in the middle of a drain
        do_reset();
        run_stream(4 * L + 6, 2);
        en = 1'b1; dec_valid = 1'b1; tbu0_wr_en = 1'b1; #1;
        chk("pre-rst out_valid", out_valid, 1);
        rst = 1'b1; #1;
        chk("mid-drain rst out_valid", out_valid, 0);
        chk("mid-drain rst mem_raddr", mem_raddr, L - 1);
        chk("mid-drain rst tbu_en", {tbu0_en, tbu1_en}, 0);
        do_reset();
        run_stream(L + 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
